union_find_node: RTL and testbench

//  Per-vertex processing unit of the parallel union-find decoder; the node-side endpoint of every neighbor link.
//  - Holds the cluster root of this vertex.
//  - Issues one-shot grow pulses into its incident links during STAGE_GROW_BOUNDARY.
//  - During STAGE_MERGE, adopts the minimum root seen across fully grown links.
//  - Reports occupancy, boundary status and merge stability to the decoder controller.

---
 rtl/uf_pkg.sv | 29 ++
 rtl/union_find_node_if.sv | 28 ++
 rtl/root_min_tree.sv | 26 ++
 rtl/union_find_node.sv | 130 +++++++++++++
 tb/tb_union_find_node.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uf_pkg.sv
// rtl/uf_pkg.sv - shared types and helpers for the union-find decoder
package uf_pkg;

  // Controller stage broadcast to every vertex
  typedef enum logic [1:0] {
    STAGE_IDLE          = 2'd0,
    STAGE_GROW_BOUNDARY = 2'd1,
    STAGE_MERGE         = 2'd2,
    STAGE_RESERVED      = 2'd3
  } stage_t;

  // Per-vertex sequencing state
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_GROW_PULSE = 2'd1,
    S_GROW_WAIT  = 2'd2,
    S_MERGE      = 2'd3
  } node_state_t;

  // Consecutive unchanged MERGE cycles before a vertex reports stable;
  // the link adds one register stage between neighbouring roots.
  localparam int STABLE_CYCLES = 2;

  // All-ones address marks a vertex that belongs to no cluster
  function automatic logic [31:0] null_root(input int aw);
    return 32'((64'd1 << aw) - 64'd1);
  endfunction

endpackage

// File: rtl/union_find_node_if.sv
// rtl/union_find_node_if.sv - bundle of all neighbor-link signals of one vertex
interface union_find_node_if #(
  parameter int ADDRESS_WIDTH  = 12,
  parameter int NEIGHBOR_COUNT = 4
);

  logic [NEIGHBOR_COUNT-1:0]               link_fully_grown;
  logic [NEIGHBOR_COUNT*ADDRESS_WIDTH-1:0] link_peer_root;
  logic [ADDRESS_WIDTH-1:0]                link_root_out;
  logic [NEIGHBOR_COUNT-1:0]               link_increase;

  // Node side: publishes its root and grow pulses, reads link status
  modport master (
    input  link_fully_grown,
    input  link_peer_root,
    output link_root_out,
    output link_increase
  );

  // Link side: the mirror view
  modport slave (
    output link_fully_grown,
    output link_peer_root,
    input  link_root_out,
    input  link_increase
  );

endinterface

// File: rtl/root_min_tree.sv
// rtl/root_min_tree.sv - combinational unsigned minimum over inputs qualified by valid
module root_min_tree #(
  parameter int WIDTH = 12,
  parameter int COUNT = 4
) (
  input  logic [COUNT*WIDTH-1:0] data,
  input  logic [COUNT-1:0]       valid,
  output logic [WIDTH-1:0]       min_value,
  output logic                   any_valid
);

  // Invalid lanes never win; with no valid lane the result is all-ones
  always_comb begin
    min_value = '1;
    any_valid = 1'b0;
    for (int i = 0; i < COUNT; i++) begin
      if (valid[i]) begin
        any_valid = 1'b1;
        if (data[i*WIDTH +: WIDTH] < min_value) begin
          min_value = data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/union_find_node.sv
// rtl/union_find_node.sv - per-vertex union-find unit: root holder, grow pulser, min-root merger
module union_find_node
  import uf_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 12,
  parameter int NEIGHBOR_COUNT = 4,
  parameter int ADDRESS        = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     initialize,
  input  logic                     is_error_syndrome,
  input  stage_t                   stage,
  input  logic                     grow_enable,
  union_find_node_if.master        links,
  output logic [ADDRESS_WIDTH-1:0] root,
  output logic                     is_occupied,
  output logic                     is_boundary,
  output logic                     merge_stable
);

  localparam logic [ADDRESS_WIDTH-1:0] NULL_ROOT = ADDRESS_WIDTH'(null_root(ADDRESS_WIDTH));
  localparam logic [ADDRESS_WIDTH-1:0] OWN_ROOT  = ADDRESS_WIDTH'(ADDRESS);
  localparam logic [1:0]               CNT_MAX   = 2'(STABLE_CYCLES);

  node_state_t                state;
  stage_t                     stage_q;
  logic [ADDRESS_WIDTH-1:0]   root_q;
  logic [ADDRESS_WIDTH-1:0]   root_out_q;
  logic [NEIGHBOR_COUNT-1:0]  increase_q;
  logic [1:0]                 stable_cnt;

  logic [ADDRESS_WIDTH-1:0]   candidate;
  logic                       has_candidate;
  logic                       root_change;
  logic [NEIGHBOR_COUNT-1:0]  grow_mask;

  root_min_tree #(
    .WIDTH (ADDRESS_WIDTH),
    .COUNT (NEIGHBOR_COUNT)
  ) u_min (
    .data      (links.link_peer_root),
    .valid     (links.link_fully_grown),
    .min_value (candidate),
    .any_valid (has_candidate)
  );

  // Status flags and the grow mask come straight from registered state
  always_comb begin
    is_occupied = (root_q != NULL_ROOT);
    is_boundary = is_occupied && !(&links.link_fully_grown);
    grow_mask   = {NEIGHBOR_COUNT{is_occupied & grow_enable}} & ~links.link_fully_grown;
    root_change = has_candidate && (candidate < root_q);
  end

  // Stage sequencing, one-shot grow pulse, monotonic root merge and stability count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      stage_q    <= STAGE_IDLE;
      root_q     <= NULL_ROOT;
      root_out_q <= NULL_ROOT;
      increase_q <= '0;
      stable_cnt <= '0;
    end else begin
      stage_q    <= stage;
      root_out_q <= root_q;
      if (initialize) begin
        root_q     <= is_error_syndrome ? OWN_ROOT : NULL_ROOT;
        increase_q <= '0;
        stable_cnt <= '0;
        state      <= S_IDLE;
      end else begin
        increase_q <= '0;
        case (state)
          S_IDLE: begin
            if (stage == STAGE_GROW_BOUNDARY && stage_q != STAGE_GROW_BOUNDARY) begin
              state      <= S_GROW_PULSE;
              increase_q <= grow_mask;
            end else if (stage == STAGE_MERGE) begin
              state <= S_MERGE;
            end
          end
          S_GROW_PULSE: begin
            case (stage)
              STAGE_GROW_BOUNDARY: state <= S_GROW_WAIT;
              STAGE_MERGE:         state <= S_MERGE;
              default:             state <= S_IDLE;
            endcase
          end
          S_GROW_WAIT: begin
            if (stage == STAGE_MERGE) begin
              state <= S_MERGE;
            end else if (stage != STAGE_GROW_BOUNDARY) begin
              state <= S_IDLE;
            end
          end
          S_MERGE: begin
            if (stage == STAGE_IDLE) begin
              state <= S_IDLE;
            end else if (stage == STAGE_GROW_BOUNDARY) begin
              state      <= S_GROW_PULSE;
              increase_q <= grow_mask;
            end
          end
          default: state <= S_IDLE;
        endcase

        if (state == S_MERGE) begin
          if (root_change) begin
            root_q     <= candidate;
            stable_cnt <= '0;
          end else if (stage != stage_q) begin
            stable_cnt <= '0;
          end else if (stable_cnt != CNT_MAX) begin
            stable_cnt <= stable_cnt + 2'd1;
          end
        end else begin
          stable_cnt <= '0;
        end
      end
    end
  end

  assign links.link_root_out = root_out_q;
  assign links.link_increase = increase_q;
  assign root                = root_q;
  assign merge_stable        = (stable_cnt == CNT_MAX);

endmodule

// File: tb/tb_union_find_node.sv
// tb/tb_union_find_node.sv - directed self-checking bench for union_find_node
module tb_union_find_node;
  import uf_pkg::*;

  localparam int AW = 12;
  localparam logic [AW-1:0] NUL = 12'hFFF;

  logic   clk = 1'b0;
  logic   reset;
  logic   initialize;
  logic   is_error_syndrome;
  stage_t stage;
  logic   grow_enable;
  logic [AW-1:0] root;
  logic   is_occupied, is_boundary, merge_stable;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  union_find_node_if #(.ADDRESS_WIDTH(AW), .NEIGHBOR_COUNT(4)) mif ();

  union_find_node #(.ADDRESS_WIDTH(AW), .NEIGHBOR_COUNT(4), .ADDRESS(5)) dut (
    .clk               (clk),
    .reset             (reset),
    .initialize        (initialize),
    .is_error_syndrome (is_error_syndrome),
    .stage             (stage),
    .grow_enable       (grow_enable),
    .links             (mif.master),
    .root              (root),
    .is_occupied       (is_occupied),
    .is_boundary       (is_boundary),
    .merge_stable      (merge_stable)
  );

  // Four-vertex chain 2-4-6-8 joined by three link models
  logic            ch_init;
  logic [3:0]      ch_syn;
  stage_t          ch_stage;
  logic [3:0][1:0]    ch_lfg;
  logic [3:0][2*AW-1:0] ch_peer;
  logic [3:0][AW-1:0] ch_rout;
  logic [3:0][1:0]    ch_inc;
  logic [3:0][AW-1:0] ch_root;
  logic [3:0]      ch_occ, ch_bnd, ch_stable;
  logic [2:0][1:0]    lc;
  logic [2:0][AW-1:0] pr_right;
  logic [2:0][AW-1:0] pr_left;

  genvar g;
  for (g = 0; g < 4; g++) begin : g_chain
    union_find_node_if #(.ADDRESS_WIDTH(AW), .NEIGHBOR_COUNT(2)) cif ();
    assign cif.link_fully_grown = ch_lfg[g];
    assign cif.link_peer_root   = ch_peer[g];
    assign ch_rout[g]           = cif.link_root_out;
    assign ch_inc[g]            = cif.link_increase;
    union_find_node #(.ADDRESS_WIDTH(AW), .NEIGHBOR_COUNT(2), .ADDRESS(2*(g+1))) node (
      .clk               (clk),
      .reset             (reset),
      .initialize        (ch_init),
      .is_error_syndrome (ch_syn[g]),
      .stage             (ch_stage),
      .grow_enable       (1'b1),
      .links             (cif.master),
      .root              (ch_root[g]),
      .is_occupied       (ch_occ[g]),
      .is_boundary       (ch_bnd[g]),
      .merge_stable      (ch_stable[g])
    );
  end

  // Link model: grows by one per incident pulse, fully grown at 2; peer root registered once
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      lc       <= '0;
      pr_right <= {3{NUL}};
      pr_left  <= {3{NUL}};
    end else begin
      for (int k = 0; k < 3; k++) begin
        logic [2:0] sum;
        sum = {1'b0, lc[k]} + {2'b0, ch_inc[k][1]} + {2'b0, ch_inc[k+1][0]};
        if (ch_init) lc[k] <= 2'd0;
        else         lc[k] <= (sum >= 3'd2) ? 2'd2 : sum[1:0];
        pr_right[k] <= ch_rout[k];
        pr_left[k]  <= ch_rout[k+1];
      end
    end
  end

  // Lane 0 faces the lower-address neighbour, lane 1 the higher one; end lanes are unused
  always_comb begin
    ch_lfg[0]  = {lc[0] == 2'd2, 1'b0};
    ch_lfg[1]  = {lc[1] == 2'd2, lc[0] == 2'd2};
    ch_lfg[2]  = {lc[2] == 2'd2, lc[1] == 2'd2};
    ch_lfg[3]  = {1'b0, lc[2] == 2'd2};
    ch_peer[0] = {pr_left[0], NUL};
    ch_peer[1] = {pr_left[1], pr_right[0]};
    ch_peer[2] = {pr_left[2], pr_right[1]};
    ch_peer[3] = {NUL, pr_right[2]};
  end

  typedef struct {
    logic       syn;
    logic       ge;
    logic [3:0] lfg;
    logic [3:0] exp_inc;
    logic       exp_bnd;
  } grow_vec_t;

  typedef struct {
    logic          syn;
    logic [3:0]    lfg;
    logic [4*AW-1:0] peers;
    logic [AW-1:0] exp_root;
  } merge_vec_t;

  grow_vec_t  gv[6];
  merge_vec_t mv[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic init_node(input logic syn);
    initialize        = 1'b1;
    is_error_syndrome = syn;
    step();
    initialize        = 1'b0;
  endtask

  task automatic ch_phase(input stage_t s, input int n);
    ch_stage = s;
    repeat (n) step();
  endtask

  initial begin
    gv[0] = '{1'b1, 1'b1, 4'b0010, 4'b1101, 1'b1};
    gv[1] = '{1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1};
    gv[2] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0};
    gv[3] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1};
    gv[4] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0};
    gv[5] = '{1'b1, 1'b1, 4'b1010, 4'b0101, 1'b1};

    mv[0] = '{1'b1, 4'b0101, {12'hFFF, 12'h009, 12'h001, 12'h003}, 12'h003};
    mv[1] = '{1'b1, 4'b0000, {12'h000, 12'h000, 12'h000, 12'h000}, 12'h005};
    mv[2] = '{1'b1, 4'b1111, {12'h006, 12'h007, 12'h008, 12'h009}, 12'h005};
    mv[3] = '{1'b0, 4'b0001, {12'hFFF, 12'hFFF, 12'hFFF, 12'h007}, 12'h007};
    mv[4] = '{1'b0, 4'b0000, {12'h001, 12'h001, 12'h001, 12'h001}, 12'hFFF};
    mv[5] = '{1'b1, 4'b1110, {12'h004, 12'h004, 12'h002, 12'h000}, 12'h002};

    reset = 1'b1; initialize = 1'b0; is_error_syndrome = 1'b0;
    stage = STAGE_IDLE; grow_enable = 1'b0;
    mif.link_fully_grown = '0; mif.link_peer_root = {4{NUL}};
    ch_init = 1'b0; ch_syn = 4'b1001; ch_stage = STAGE_IDLE;
    repeat (2) step();

    check("reset_root", root, NUL);
    check("reset_root_out", mif.link_root_out, NUL);
    check("reset_inc", mif.link_increase, 0);
    check("reset_occ", is_occupied, 0);
    check("reset_bnd", is_boundary, 0);
    check("reset_stable", merge_stable, 0);
    reset = 1'b0;
    step();

    // Seeded vertex
    init_node(1'b1);
    check("init_root", root, 12'h005);
    check("init_occ", is_occupied, 1);
    check("init_bnd", is_boundary, 1);
    check("init_inc", mif.link_increase, 0);
    step();
    check("init_root_out", mif.link_root_out, 12'h005);

    // One pulse on GROW entry, then silence while held even as grow_enable toggles
    grow_enable = 1'b1; mif.link_fully_grown = 4'b0010;
    stage = STAGE_GROW_BOUNDARY;
    step();
    check("pulse", mif.link_increase, 4'b1101);
    for (int i = 0; i < 20; i++) begin
      step();
      grow_enable = i[0];
      check("pulse_hold", mif.link_increase, 0);
    end
    stage = STAGE_IDLE; grow_enable = 1'b1;
    step();

    // Table: grow pulses
    for (int i = 0; i < 6; i++) begin
      init_node(gv[i].syn);
      grow_enable = gv[i].ge; mif.link_fully_grown = gv[i].lfg;
      stage = STAGE_IDLE;
      step();
      stage = STAGE_GROW_BOUNDARY;
      step();
      check($sformatf("grow_inc[%0d]", i), mif.link_increase, gv[i].exp_inc);
      check($sformatf("grow_bnd[%0d]", i), is_boundary, gv[i].exp_bnd);
      step();
      check($sformatf("grow_off[%0d]", i), mif.link_increase, 0);
      stage = STAGE_IDLE;
      step();
    end

    // Merge timing: adopt min on second edge, stable two unchanged cycles later
    init_node(1'b1);
    mif.link_fully_grown = 4'b0101;
    mif.link_peer_root   = {12'hFFF, 12'h009, 12'h001, 12'h003};
    stage = STAGE_MERGE;
    step();
    check("merge_pre", root, 12'h005);
    step();
    check("merge_root", root, 12'h003);
    check("merge_st0", merge_stable, 0);
    step();
    check("merge_st1", merge_stable, 0);
    check("merge_root_out", mif.link_root_out, 12'h003);
    step();
    check("merge_st2", merge_stable, 1);
    stage = STAGE_IDLE;
    step();
    check("merge_st_clr", merge_stable, 0);

    // Table: merge minimum
    for (int i = 0; i < 6; i++) begin
      init_node(mv[i].syn);
      mif.link_fully_grown = mv[i].lfg;
      mif.link_peer_root   = mv[i].peers;
      stage = STAGE_MERGE;
      repeat (4) step();
      check($sformatf("merge_min[%0d]", i), root, mv[i].exp_root);
      stage = STAGE_IDLE;
      step();
    end

    // Async reset during the pulse cycle
    mif.link_fully_grown = '0; mif.link_peer_root = {4{NUL}};
    init_node(1'b1);
    step();
    stage = STAGE_GROW_BOUNDARY;
    step();
    check("rst_pulse_pre", mif.link_increase, 4'b1111);
    reset = 1'b1;
    #1;
    check("rst_pulse_inc", mif.link_increase, 0);
    check("rst_pulse_root", root, NUL);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_no_pulse", mif.link_increase, 0);
    end
    stage = STAGE_IDLE;
    step();

    // Chain convergence: syndromes at 2 and 8
    ch_init = 1'b1;
    step();
    ch_init = 1'b0;
    ch_phase(STAGE_GROW_BOUNDARY, 3);
    ch_phase(STAGE_IDLE, 3);
    ch_phase(STAGE_GROW_BOUNDARY, 3);
    ch_phase(STAGE_IDLE, 3);
    ch_phase(STAGE_MERGE, 12);
    ch_phase(STAGE_IDLE, 3);
    ch_phase(STAGE_GROW_BOUNDARY, 3);
    ch_phase(STAGE_IDLE, 3);
    ch_phase(STAGE_MERGE, 24);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("chain_root[%0d]", i), ch_root[i], 12'h002);
      check($sformatf("chain_stable[%0d]", i), ch_stable[i], 1);
    end
    ch_phase(STAGE_IDLE, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
